// File: rtl/hc4e_pkg.sv
// Shared definitions for the HC4E clock sequencer: FSM state encoding and
// prescaler width.
package hc4e_pkg;

  typedef enum logic [1:0] {
    HALT    = 2'd0,
    RUN_LO  = 2'd1,
    RUN_HI  = 2'd2,
    STEP_HI = 2'd3
  } state_t;

  localparam int unsigned PRESC_W = 24;

endpackage

// File: rtl/hc4e_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-sample debouncer and
// rising-edge detector producing a single-cycle pulse.
module hc4e_debounce #(
  parameter int unsigned DEB_CYCLES = 200_000
) (
  input  logic clock,
  input  logic nReset,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Two-stage synchronizer for the asynchronous button input.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

  // Debounced level flips only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync_b == level) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      level <= sync_b;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign pulse = level & ~level_d;

endmodule

// File: rtl/hc4e_clock_sequencer.sv
// Core clock sequencer: free-running RUN mode, single step, run/halt toggle
// and address breakpoint, with a retired-instruction counter.
module hc4e_clock_sequencer
  import hc4e_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 10_000_000,
  parameter int unsigned STEP_HALF   = 1000,
  parameter int unsigned DEB_CYCLES  = 200_000,
  parameter int unsigned START_RUN   = 1
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        bp_en,
  input  logic [7:0]  bp_addr,
  input  logic [7:0]  pc_in,
  output logic        cpu_clk,
  output logic        halted,
  output logic        bp_hit,
  output logic [15:0] retired
);

  localparam logic [PRESC_W-1:0] RUN_LAST  = PRESC_W'(HALF_PERIOD - 1);
  localparam logic [PRESC_W-1:0] STEP_LAST = PRESC_W'(STEP_HALF - 1);
  localparam state_t             RST_STATE = (START_RUN != 0) ? RUN_LO : HALT;

  state_t               state;
  state_t               state_next;
  logic [PRESC_W-1:0]   presc;
  logic                 halt_pend;
  logic                 halt_pend_next;
  logic                 skip_bp;
  logic                 skip_bp_next;
  logic                 bp_hit_next;
  logic                 retire_inc;
  logic                 tc;
  logic                 halt_req;
  logic                 bp_match;
  logic                 run_p;
  logic                 step_p;

  hc4e_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clock  (clock),
    .nReset (nReset),
    .btn    (btn_run),
    .pulse  (run_p)
  );

  hc4e_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clock  (clock),
    .nReset (nReset),
    .btn    (btn_step),
    .pulse  (step_p)
  );

  // Next-state, stop-condition and side-flag decode.
  always_comb begin
    state_next     = state;
    halt_pend_next = halt_pend;
    skip_bp_next   = skip_bp;
    bp_hit_next    = bp_hit;
    retire_inc     = 1'b0;
    tc             = (presc == ((state == STEP_HI) ? STEP_LAST : RUN_LAST));
    halt_req       = halt_pend | run_p;
    bp_match       = bp_en && (pc_in == bp_addr) && !skip_bp;
    case (state)
      HALT: begin
        if (run_p) begin
          state_next   = RUN_LO;
          skip_bp_next = 1'b1;
        end else if (step_p) begin
          state_next = STEP_HI;
          retire_inc = 1'b1;
        end
      end
      RUN_LO: begin
        // A run press landing on the tc cycle itself counts as pending.
        halt_pend_next = halt_req;
        if (tc) begin
          if (halt_req || bp_match) begin
            state_next     = HALT;
            bp_hit_next    = bp_match;
            halt_pend_next = 1'b0;
          end else begin
            state_next   = RUN_HI;
            retire_inc   = 1'b1;
            skip_bp_next = 1'b0;
          end
        end
      end
      RUN_HI: begin
        halt_pend_next = halt_req;
        if (tc) begin
          state_next = RUN_LO;
        end
      end
      STEP_HI: begin
        if (tc) begin
          state_next = HALT;
        end
      end
      default: begin
        state_next = HALT;
      end
    endcase
  end

  // State, flags and prescaler registers.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state     <= RST_STATE;
      presc     <= '0;
      halt_pend <= 1'b0;
      skip_bp   <= 1'b1;
      bp_hit    <= 1'b0;
    end else begin
      state     <= state_next;
      halt_pend <= halt_pend_next;
      skip_bp   <= skip_bp_next;
      bp_hit    <= bp_hit_next;
      if ((state_next != state) || (state == HALT)) begin
        presc <= '0;
      end else begin
        presc <= presc + PRESC_W'(1);
      end
    end
  end

  // Registered outputs decoded from the next state.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      cpu_clk <= 1'b0;
      halted  <= (START_RUN == 0);
      retired <= '0;
    end else begin
      cpu_clk <= (state_next == RUN_HI) || (state_next == STEP_HI);
      halted  <= (state_next == HALT);
      if (retire_inc) begin
        retired <= retired + 16'd1;
      end
    end
  end

endmodule
